// File: rtl/bash_io_arbiter.sv
// Two-client round-robin arbiter sharing one VideoMemory bash line handshake bundle.
// Routing is purely combinational; ownership is released on completion, withdrawal or watchdog expiry.
module bash_io_arbiter #(
  parameter int TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  output logic        busy,
  output logic        timeout_err,
  input  logic [1:0]  c_in_solved,
  input  logic [1:0]  c_in_require_line,
  input  logic [1:0]  c_in_newASCII_ready,
  input  logic [15:0] c_lineIn,
  input  logic [1:0]  c_lineOut_nextASCII,
  output logic [1:0]  c_out_solved,
  output logic [1:0]  c_out_require_line,
  output logic [1:0]  c_lineIn_nextASCII,
  output logic [1:0]  c_out_newASCII_ready,
  output logic [5:0]  c_out_lineLen,
  output logic [7:0]  c_lineOut,
  output logic        in_solved,
  input  logic        out_solved,
  output logic        in_require_line,
  input  logic        out_require_line,
  input  logic        lineIn_nextASCII,
  output logic        in_newASCII_ready,
  output logic [7:0]  lineIn,
  output logic        lineOut_nextASCII,
  input  logic        out_newASCII_ready,
  input  logic [5:0]  out_lineLen,
  input  logic [7:0]  lineOut
);

  localparam logic [15:0] WD_MAX = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, OWN, DRAIN} state_t;

  state_t      r_state, w_nextState;
  logic        r_owner, w_nextOwner;
  logic        r_last, w_nextLast;
  logic [15:0] r_wd, w_nextWd;
  logic [1:0]  r_gnt, w_nextGnt;
  logic        r_timeoutErr, w_nextTimeoutErr;

  logic w_route;
  logic w_own;
  logic w_done;
  logic w_withdraw;
  logic w_activity;
  logic [1:0] w_ownerMask;

  assign w_route     = (r_state != IDLE);
  assign w_own       = (r_state == OWN);
  assign w_ownerMask = r_owner ? 2'b10 : 2'b01;

  assign w_done     = out_solved && c_in_solved[r_owner];
  assign w_withdraw = !req[r_owner] && !out_newASCII_ready && !c_in_newASCII_ready[r_owner];
  assign w_activity = lineIn_nextASCII || out_solved || out_require_line ||
                      out_newASCII_ready || c_lineOut_nextASCII[r_owner];

  assign gnt         = r_gnt;
  assign busy        = (r_gnt != 2'b00);
  assign timeout_err = r_timeoutErr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      r_last       <= 1'b1;
      r_wd         <= 16'd0;
      r_gnt        <= 2'b00;
      r_timeoutErr <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_owner      <= w_nextOwner;
      r_last       <= w_nextLast;
      r_wd         <= w_nextWd;
      r_gnt        <= w_nextGnt;
      r_timeoutErr <= w_nextTimeoutErr;
    end
  end

  // Exit checks are ordered: completion beats watchdog, watchdog beats withdrawal.
  always_comb begin
    w_nextState      = r_state;
    w_nextOwner      = r_owner;
    w_nextLast       = r_last;
    w_nextGnt        = r_gnt;
    w_nextWd         = 16'd0;
    w_nextTimeoutErr = 1'b0;
    case (r_state)
      IDLE: begin
        if (req != 2'b00) begin
          w_nextOwner = (req == 2'b11) ? ~r_last : req[1];
          w_nextGnt   = w_nextOwner ? 2'b10 : 2'b01;
          w_nextState = OWN;
        end
      end
      OWN: begin
        if (w_done) begin
          w_nextState = DRAIN;
        end else if (r_wd == WD_MAX) begin
          w_nextState      = DRAIN;
          w_nextTimeoutErr = 1'b1;
        end else if (w_withdraw) begin
          w_nextState = DRAIN;
        end else if (w_activity) begin
          w_nextWd = 16'd0;
        end else begin
          w_nextWd = r_wd + 16'd1;
        end
      end
      DRAIN: begin
        w_nextState = IDLE;
        w_nextGnt   = 2'b00;
        w_nextLast  = r_owner;
      end
      default: begin
        w_nextState = IDLE;
        w_nextGnt   = 2'b00;
      end
    endcase
  end

  // DRAIN keeps the owner connected but stops driving new requests into VideoMemory.
  always_comb begin
    in_solved            = w_own & c_in_solved[r_owner];
    in_require_line      = w_own & c_in_require_line[r_owner];
    in_newASCII_ready    = w_own & c_in_newASCII_ready[r_owner];
    lineOut_nextASCII    = w_route & c_lineOut_nextASCII[r_owner];
    lineIn               = 8'h00;
    c_out_solved         = 2'b00;
    c_out_require_line   = 2'b00;
    c_lineIn_nextASCII   = 2'b00;
    c_out_newASCII_ready = 2'b00;
    c_out_lineLen        = out_lineLen;
    c_lineOut            = lineOut;
    if (w_route) begin
      lineIn               = r_owner ? c_lineIn[15:8] : c_lineIn[7:0];
      c_out_solved         = w_ownerMask & {2{out_solved}};
      c_out_require_line   = w_ownerMask & {2{out_require_line}};
      c_lineIn_nextASCII   = w_ownerMask & {2{lineIn_nextASCII}};
      c_out_newASCII_ready = w_ownerMask & {2{out_newASCII_ready}};
    end
  end

endmodule

// File: tb/tb_bash_io_arbiter.sv
// Self-checking bench for bash_io_arbiter: directed scenarios plus randomized traffic
// compared against a rule-level reference model of the arbitration behaviour.
module tb_bash_io_arbiter;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  gnt;
  logic        busy, timeout_err;
  logic [1:0]  c_in_solved = 2'b00, c_in_require_line = 2'b00, c_in_newASCII_ready = 2'b00;
  logic [15:0] c_lineIn = 16'h0000;
  logic [1:0]  c_lineOut_nextASCII = 2'b00;
  logic [1:0]  c_out_solved, c_out_require_line, c_lineIn_nextASCII, c_out_newASCII_ready;
  logic [5:0]  c_out_lineLen;
  logic [7:0]  c_lineOut;
  logic        in_solved, in_require_line, in_newASCII_ready, lineOut_nextASCII;
  logic        out_solved = 1'b0, out_require_line = 1'b0, lineIn_nextASCII = 1'b0;
  logic        out_newASCII_ready = 1'b0;
  logic [7:0]  lineIn;
  logic [5:0]  out_lineLen = 6'd0;
  logic [7:0]  lineOut = 8'h00;

  int checks = 0;
  int failures = 0;

  // Reference model: phase 0 = idle, 1 = owned, 2 = draining
  int         mPhase;
  logic       mOwner, mLast, mTerr;
  int         mWd;
  logic [1:0] mGnt;

  always #5 clk = ~clk;

  bash_io_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .busy(busy), .timeout_err(timeout_err),
    .c_in_solved(c_in_solved), .c_in_require_line(c_in_require_line),
    .c_in_newASCII_ready(c_in_newASCII_ready), .c_lineIn(c_lineIn),
    .c_lineOut_nextASCII(c_lineOut_nextASCII), .c_out_solved(c_out_solved),
    .c_out_require_line(c_out_require_line), .c_lineIn_nextASCII(c_lineIn_nextASCII),
    .c_out_newASCII_ready(c_out_newASCII_ready), .c_out_lineLen(c_out_lineLen),
    .c_lineOut(c_lineOut), .in_solved(in_solved), .out_solved(out_solved),
    .in_require_line(in_require_line), .out_require_line(out_require_line),
    .lineIn_nextASCII(lineIn_nextASCII), .in_newASCII_ready(in_newASCII_ready),
    .lineIn(lineIn), .lineOut_nextASCII(lineOut_nextASCII),
    .out_newASCII_ready(out_newASCII_ready), .out_lineLen(out_lineLen), .lineOut(lineOut)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mPhase <= 0; mOwner <= 1'b0; mLast <= 1'b1; mWd <= 0; mGnt <= 2'b00; mTerr <= 1'b0;
    end else begin
      case (mPhase)
        0: if (req != 2'b00) begin
             mOwner <= (req == 2'b11) ? !mLast : req[1];
             mGnt   <= (((req == 2'b11) ? !mLast : req[1]) == 1'b1) ? 2'b10 : 2'b01;
             mPhase <= 1;
             mWd    <= 0;
           end
        1: begin
             if (out_solved && c_in_solved[mOwner]) begin
               mPhase <= 2; mWd <= 0;
             end else if (mWd == TO - 1) begin
               mPhase <= 2; mWd <= 0; mTerr <= 1'b1;
             end else if (!req[mOwner] && !out_newASCII_ready && !c_in_newASCII_ready[mOwner]) begin
               mPhase <= 2; mWd <= 0;
             end else if (lineIn_nextASCII || out_solved || out_require_line ||
                          out_newASCII_ready || c_lineOut_nextASCII[mOwner]) begin
               mWd <= 0;
             end else begin
               mWd <= (mWd + 1 > TO - 1) ? TO - 1 : mWd + 1;
             end
           end
        default: begin
             mPhase <= 0; mGnt <= 2'b00; mLast <= mOwner; mTerr <= 1'b0;
           end
      endcase
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; req = 2'b11; c_in_newASCII_ready = 2'b11; out_newASCII_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (gnt !== 2'b00 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_gnt got=%b/%b want=00/0", gnt, busy);
    end
    checks++;
    if (in_newASCII_ready !== 1'b0 || timeout_err !== 1'b0) begin
      failures++; $display("FAIL reset_outputs ready=%b terr=%b want 0/0", in_newASCII_ready, timeout_err);
    end
    c_in_newASCII_ready = 2'b00; out_newASCII_ready = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (gnt !== 2'b01) begin
      failures++; $display("FAIL reset_first_grant got=%b want=01", gnt);
    end
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    c_in_solved = 2'b01; out_solved = 1'b1;
    #1;
    checks++;
    if (in_solved !== 1'b1 || c_out_solved !== 2'b01) begin
      failures++; $display("FAIL sim_route in_solved=%b c_out_solved=%b want 1/01", in_solved, c_out_solved);
    end
    @(posedge clk); #1;
    @(negedge clk);
    out_solved = 1'b0;
    #1;
    checks++;
    if (gnt !== 2'b01 || in_solved !== 1'b0) begin
      failures++; $display("FAIL sim_drain gnt=%b in_solved=%b want 01/0", gnt, in_solved);
    end
    c_in_solved = 2'b00;
    @(posedge clk); #1;
    checks++;
    if (gnt !== 2'b00) begin
      failures++; $display("FAIL sim_idle gnt=%b want 00", gnt);
    end
    @(posedge clk); #1;
    checks++;
    if (gnt !== 2'b10) begin
      failures++; $display("FAIL sim_second_grant gnt=%b want 10", gnt);
    end
  endtask

  task automatic test_echo();
    logic [7:0] bytes [3];
    bytes[0] = 8'h61; bytes[1] = 8'h62; bytes[2] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_newASCII_ready = 1'b1;
      lineOut = bytes[i];
      c_lineOut_nextASCII = 2'($urandom_range(0, 3));
      #1;
      checks++;
      if (c_out_newASCII_ready !== 2'b10 || c_lineOut !== bytes[i] || gnt !== 2'b10) begin
        failures++;
        $display("FAIL echo_byte%0d ready=%b data=%h gnt=%b want 10/%h/10", i, c_out_newASCII_ready, c_lineOut, gnt, bytes[i]);
      end
      checks++;
      if (lineOut_nextASCII !== c_lineOut_nextASCII[1]) begin
        failures++; $display("FAIL echo_next%0d got=%b want=%b", i, lineOut_nextASCII, c_lineOut_nextASCII[1]);
      end
      checks++;
      if ({c_out_solved[0], c_out_require_line[0], c_lineIn_nextASCII[0], c_out_newASCII_ready[0]} !== 4'b0000) begin
        failures++; $display("FAIL echo_client0_quiet got=%b%b%b%b want 0000",
                             c_out_solved[0], c_out_require_line[0], c_lineIn_nextASCII[0], c_out_newASCII_ready[0]);
      end
      @(posedge clk);
    end
    @(negedge clk);
    out_newASCII_ready = 1'b0; c_lineOut_nextASCII = 2'b00;
    c_in_solved = 2'b10; out_solved = 1'b1;
    @(negedge clk);
    out_solved = 1'b0; c_in_solved = 2'b00; req = 2'b00;
    @(posedge clk);
    @(posedge clk); #1;
    checks++;
    if (gnt !== 2'b00) begin
      failures++; $display("FAIL echo_release gnt=%b want 00", gnt);
    end
  endtask

  task automatic test_withdraw();
    @(negedge clk);
    req = 2'b01;
    @(posedge clk); #1;
    checks++;
    if (gnt !== 2'b01) begin
      failures++; $display("FAIL wd_grant gnt=%b want 01", gnt);
    end
    @(negedge clk);
    req = 2'b00; c_in_solved = 2'b01;
    #1;
    checks++;
    if (in_solved !== 1'b1) begin
      failures++; $display("FAIL wd_own_route in_solved=%b want 1", in_solved);
    end
    @(posedge clk); #1;
    checks++;
    if (gnt !== 2'b01 || in_solved !== 1'b0 || timeout_err !== 1'b0) begin
      failures++; $display("FAIL wd_drain gnt=%b in_solved=%b terr=%b want 01/0/0", gnt, in_solved, timeout_err);
    end
    @(posedge clk); #1;
    checks++;
    if (gnt !== 2'b00 || timeout_err !== 1'b0) begin
      failures++; $display("FAIL wd_idle gnt=%b terr=%b want 00/0", gnt, timeout_err);
    end
    @(negedge clk);
    c_in_solved = 2'b00;
  endtask

  task automatic test_watchdog();
    @(negedge clk);
    req = 2'b10;
    @(posedge clk); #1;
    checks++;
    if (gnt !== 2'b10) begin
      failures++; $display("FAIL dog_grant gnt=%b want 10", gnt);
    end
    for (int i = 1; i < TO; i++) begin
      @(posedge clk); #1;
      checks++;
      if (timeout_err !== 1'b0 || gnt !== 2'b10) begin
        failures++; $display("FAIL dog_wait%0d terr=%b gnt=%b want 0/10", i, timeout_err, gnt);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (timeout_err !== 1'b1 || gnt !== 2'b10) begin
      failures++; $display("FAIL dog_pulse terr=%b gnt=%b want 1/10", timeout_err, gnt);
    end
    @(negedge clk);
    req = 2'b00;
    @(posedge clk); #1;
    checks++;
    if (timeout_err !== 1'b0 || gnt !== 2'b00) begin
      failures++; $display("FAIL dog_release terr=%b gnt=%b want 0/00", timeout_err, gnt);
    end
  endtask

  task automatic test_reset_midstream();
    // Serve client 0 once so that without a reset the next tie would go to client 1.
    @(negedge clk); req = 2'b01;
    @(negedge clk); req = 2'b00;
    repeat (2) @(negedge clk);
    req = 2'b01;
    @(negedge clk);
    out_newASCII_ready = 1'b1; c_in_newASCII_ready = 2'b01;
    lineOut = 8'h41; c_lineIn = 16'h5542;
    #1;
    checks++;
    if (in_newASCII_ready !== 1'b1 || lineIn !== 8'h42) begin
      failures++; $display("FAIL mid_stream ready=%b lineIn=%h want 1/42", in_newASCII_ready, lineIn);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_solved, in_require_line, in_newASCII_ready, lineOut_nextASCII} !== 4'b0000 ||
        lineIn !== 8'h00 || gnt !== 2'b00 || c_out_newASCII_ready !== 2'b00) begin
      failures++; $display("FAIL mid_reset_outputs mem=%b%b%b%b lineIn=%h gnt=%b cready=%b want all 0",
                           in_solved, in_require_line, in_newASCII_ready, lineOut_nextASCII, lineIn, gnt, c_out_newASCII_ready);
    end
    checks++;
    if (c_lineOut !== 8'h41) begin
      failures++; $display("FAIL mid_reset_broadcast got=%h want 41", c_lineOut);
    end
    out_newASCII_ready = 1'b0; c_in_newASCII_ready = 2'b00; req = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (gnt !== 2'b01) begin
      failures++; $display("FAIL mid_regrant gnt=%b want 01", gnt);
    end
  endtask

  task automatic test_random();
    logic       route, own, o;
    logic [1:0] sel;
    logic [11:0] expMem;
    logic [21:0] expCli;
    logic [3:0]  expCtl;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req = 2'($urandom_range(0, 3));
      out_solved          = ($urandom_range(0, 5) == 0);
      c_in_solved         = 2'($urandom_range(0, 3));
      c_in_require_line   = 2'($urandom_range(0, 3));
      c_in_newASCII_ready = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      out_require_line    = ($urandom_range(0, 7) == 0);
      lineIn_nextASCII    = ($urandom_range(0, 7) == 0);
      out_newASCII_ready  = ($urandom_range(0, 4) == 0);
      c_lineOut_nextASCII = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      c_lineIn            = 16'($urandom);
      out_lineLen         = 6'($urandom_range(0, 63));
      lineOut             = 8'($urandom_range(0, 255));
      #1;
      route = (mPhase != 0);
      own   = (mPhase == 1);
      o     = mOwner;
      sel   = route ? (o ? 2'b10 : 2'b01) : 2'b00;
      expMem = {own & c_in_solved[o], own & c_in_require_line[o], own & c_in_newASCII_ready[o],
                route & c_lineOut_nextASCII[o], route ? (o ? c_lineIn[15:8] : c_lineIn[7:0]) : 8'h00};
      expCli = {sel & {2{out_solved}}, sel & {2{out_require_line}}, sel & {2{lineIn_nextASCII}},
                sel & {2{out_newASCII_ready}}, out_lineLen, lineOut};
      expCtl = {mGnt, mGnt != 2'b00, mTerr};
      checks++;
      if ({gnt, busy, timeout_err} !== expCtl) begin
        failures++; $display("FAIL rnd_ctl cyc=%0d got=%b want=%b", n, {gnt, busy, timeout_err}, expCtl);
      end
      checks++;
      if ({in_solved, in_require_line, in_newASCII_ready, lineOut_nextASCII, lineIn} !== expMem) begin
        failures++; $display("FAIL rnd_mem cyc=%0d got=%h want=%h", n,
                             {in_solved, in_require_line, in_newASCII_ready, lineOut_nextASCII, lineIn}, expMem);
      end
      checks++;
      if ({c_out_solved, c_out_require_line, c_lineIn_nextASCII, c_out_newASCII_ready, c_out_lineLen, c_lineOut} !== expCli) begin
        failures++; $display("FAIL rnd_client cyc=%0d got=%h want=%h", n,
                             {c_out_solved, c_out_require_line, c_lineIn_nextASCII, c_out_newASCII_ready, c_out_lineLen, c_lineOut}, expCli);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout sim time exceeded");
    $fatal(1, "[TB] stuck");
  end

  initial begin
    test_reset();
    test_simultaneous();
    test_echo();
    test_withdraw();
    test_watchdog();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bash_io_arbiter.md
# bash_io_arbiter

Two-client arbiter for the VideoMemory bash line interface. It lets two command modules (for example an echo handler and a second command handler) share the single VideoMemory handshake bundle. The block grants ownership to one client at a time, round-robin. It routes every handshake between VideoMemory and the owner with zero latency and releases ownership when the command completes, the client withdraws, or a watchdog expires. It sits between VideoMemory and the command modules, and each client keeps its native port bundle unchanged.

## Interface
- `TIMEOUT`, default 50000: idle cycles in OWN before forced release; legal range 2..65535.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in 2: per-client ownership request, level, bit i = client i.
- `gnt` out 2: one-hot grant, registered.
- `busy` out 1: `gnt != 0`.
- `timeout_err` out 1: one-cycle pulse on watchdog release.
- Client side, bit/byte i = client i:
  - `c_in_solved` in 2
  - `c_in_require_line` in 2
  - `c_in_newASCII_ready` in 2
  - `c_lineIn` in 16
  - `c_lineOut_nextASCII` in 2
  - `c_out_solved` out 2
  - `c_out_require_line` out 2
  - `c_lineIn_nextASCII` out 2
  - `c_out_newASCII_ready` out 2
  - `c_out_lineLen` out 6 (broadcast)
  - `c_lineOut` out 8 (broadcast)
- VideoMemory side:
  - `in_solved` out 1
  - `out_solved` in 1
  - `in_require_line` out 1
  - `out_require_line` in 1
  - `lineIn_nextASCII` in 1
  - `in_newASCII_ready` out 1
  - `lineIn` out 8
  - `lineOut_nextASCII` out 1
  - `out_newASCII_ready` in 1
  - `out_lineLen` in 6
  - `lineOut` in 8

## Operation
- **States:** IDLE, OWN, DRAIN. Registers: `state`, `owner` (1 bit), `last` (1 bit), `wd` (16 bit).
- **IDLE:**
  - If `req != 0`, pick the owner and go to OWN with `gnt <= onehot(owner)` and `wd <= 0`.
  - Single request: that client wins.
  - Both requesting: the client `!last` wins.
- **OWN:**
  - Memory-side outputs equal the owner's client inputs. `lineIn` is the owner's byte of `c_lineIn`.
  - Owner's `c_out_*` and `c_lineIn_nextASCII` equal the memory-side inputs.
  - Non-owner `c_out_*` and `c_lineIn_nextASCII` are 0.
  - `c_lineOut` and `c_out_lineLen` are broadcast unconditionally.
  - Exit to DRAIN, priority order:
    - (a) `out_solved && c_in_solved[owner]`: normal completion.
    - (b) `wd == TIMEOUT-1`: pulse `timeout_err`.
    - (c) `!req[owner] && !out_newASCII_ready && !c_in_newASCII_ready[owner]`: withdrawal outside any transfer.
- **DRAIN:**
  - Lasts one cycle.
  - `gnt` is held and routing stays active so the owner sees the `out_solved` pulse and clears `in_solved`.
  - Memory-side `in_solved`, `in_require_line` and `in_newASCII_ready` are forced to 0.
  - Next state IDLE, with `gnt <= 0` and `last <= owner`.
- **Watchdog:**
  - `wd` increments each OWN cycle and saturates at `TIMEOUT-1`.
  - It clears to 0 on any of `lineIn_nextASCII`, `out_solved`, `out_require_line`, `out_newASCII_ready`, or the owner's `c_lineOut_nextASCII`.
  - `wd` holds 0 outside OWN.
- **Outside OWN/DRAIN:**
  - All memory-side outputs are 0.
  - All `c_out_*` and `c_lineIn_nextASCII` are 0.
  - `c_lineOut` and `c_out_lineLen` are still broadcast.
- **Reset:** `state` = IDLE, `gnt` = 0, `owner` = 0, `last` = 1, `wd` = 0, `timeout_err` = 0, so client 0 wins the first simultaneous request. All outputs are 0 except the broadcast buses.
- **Reset mid-transfer:** VideoMemory must tolerate `in_newASCII_ready` dropping to 0 asynchronously.

## Timing
- Request to grant: `req` sampled in IDLE; `gnt` asserted on the next edge, so 1 cycle.
- Routing: purely combinational, 0 cycles. A client sees the same handshake timing it would see connected directly.
- Completion to next grant:
  - `out_solved` at edge k: DRAIN during cycle k+1.
  - IDLE at k+2.
  - New `gnt` at k+3.
- `timeout_err`: high exactly during the DRAIN cycle entered via (b).
- Requests arriving during OWN/DRAIN are not lost. They are evaluated in the next IDLE.
- `req` changes of the non-owner during OWN have no effect.

## Test plan
- **Reset:** hold `rst_n` = 0 with `req` = 2'b11 → `gnt` = 0, `in_newASCII_ready` = 0, `timeout_err` = 0. Release → `gnt` = 2'b01 one cycle later.
- **Simultaneous requests:** `req` = 2'b11 held. Client 0 completes (`c_in_solved[0]` = 1, `out_solved` pulse) → DRAIN, then `gnt` = 2'b10 three cycles after the pulse.
- **Echo passthrough with client 1 owning:**
  - VideoMemory streams "ab\0" (`out_newASCII_ready` = 1) → `c_out_newASCII_ready` = 2'b10 and client 1 receives 0x61, 0x62, 0x00. `lineOut_nextASCII` mirrors `c_lineOut_nextASCII[1]` cycle-for-cycle.
  - Client 0 outputs stay 0.
- **Withdrawal:** the owner drops `req` while idle → DRAIN next cycle, then `gnt` = 0. `timeout_err` stays 0.
- **Watchdog:** with `TIMEOUT` = 8, grant with no handshake activity → after 7 OWN cycles, `timeout_err` pulses 1 cycle and `gnt` clears 1 cycle later.
- **Reset mid-stream:** assert `rst_n` = 0 mid-line → all handshake outputs 0 immediately. The first simultaneous request after release is granted to client 0.
